// File: rtl/packet_pkg.sv
// ============================================================================
// packet_pkg
// Packet type shared by the optical link blocks, plus receive-buffer sizing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package packet_pkg;

   localparam int PKT_ID_W   = 16;
   localparam int PKT_DATA_W = 32;

   typedef struct packed {
      logic [PKT_ID_W-1:0]   dest_id;
      logic [PKT_DATA_W-1:0] data;
   } packet_t;

   localparam int RX_DEPTH_DEFAULT = 4;
   localparam int RX_CNT_W         = 16;

endpackage

`default_nettype wire

// File: rtl/pkt_fifo.sv
// ============================================================================
// pkt_fifo
// Synchronous packet FIFO; head is the entry at the read pointer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pkt_fifo
   import packet_pkg::*;
#(
   parameter int DEPTH = RX_DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  packet_t                wr_data,
   output packet_t                head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   packet_t [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/optical_rx_buffer.sv
// ============================================================================
// optical_rx_buffer
// Filters photodetector packets by router ID, buffers them, counts drops/misses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module optical_rx_buffer
   import packet_pkg::*;
#(
   parameter int DEPTH = RX_DEPTH_DEFAULT,
   parameter int CNT_W = RX_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      router_id,
   input  packet_t          in_data,
   input  logic             in_valid,
   output packet_t          out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             full,
   output logic             rx_done,
   output logic             drop_pulse,
   output logic [CNT_W-1:0] drop_count,
   output logic [CNT_W-1:0] miss_count
);

   logic                   w_match, w_miss, w_push, w_pop, w_drop, w_full;
   logic [$clog2(DEPTH):0] w_count;

   logic             rx_done_q, rx_done_d;
   logic             drop_pulse_q, drop_pulse_d;
   logic [CNT_W-1:0] drop_count_q, drop_count_d;
   logic [CNT_W-1:0] miss_count_q, miss_count_d;

   assign w_match = in_valid && (in_data.dest_id == router_id);
   assign w_miss  = in_valid && !w_match;
   assign w_pop   = out_valid && out_ready;
   // A full FIFO still accepts when a pop frees the slot in the same cycle.
   assign w_push  = w_match && (!w_full || w_pop);
   assign w_drop  = w_match && !w_push;

   pkt_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (w_push),
      .pop     (w_pop),
      .wr_data (in_data),
      .head    (out_data),
      .count   (w_count),
      .full    (w_full)
   );

   always_comb begin
      rx_done_d    = w_push;
      drop_pulse_d = w_drop;
      drop_count_d = drop_count_q;
      miss_count_d = miss_count_q;
      if (w_drop && (drop_count_q != {CNT_W{1'b1}})) begin
         drop_count_d = drop_count_q + CNT_W'(1);
      end
      if (w_miss && (miss_count_q != {CNT_W{1'b1}})) begin
         miss_count_d = miss_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_done_q    <= 1'b0;
         drop_pulse_q <= 1'b0;
         drop_count_q <= '0;
         miss_count_q <= '0;
      end else begin
         rx_done_q    <= rx_done_d;
         drop_pulse_q <= drop_pulse_d;
         drop_count_q <= drop_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign out_valid  = (w_count != '0);
   assign full       = w_full;
   assign rx_done    = rx_done_q;
   assign drop_pulse = drop_pulse_q;
   assign drop_count = drop_count_q;
   assign miss_count = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_optical_rx_buffer.sv
// ============================================================================
// tb_optical_rx_buffer
// Directed bench for optical_rx_buffer; a second instance uses 4-bit counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_optical_rx_buffer;
   import packet_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] router_id;
   packet_t     in_data;
   logic        in_valid;
   logic        out_ready;

   packet_t     out_data,   out_data_s;
   logic        out_valid,  out_valid_s;
   logic        full,       full_s;
   logic        rx_done,    rx_done_s;
   logic        drop_pulse, drop_pulse_s;
   logic [15:0] drop_count, miss_count;
   logic [3:0]  drop_count_s, miss_count_s;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   optical_rx_buffer #(.DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .router_id(router_id), .in_data(in_data),
      .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .full(full), .rx_done(rx_done),
      .drop_pulse(drop_pulse), .drop_count(drop_count), .miss_count(miss_count)
   );

   optical_rx_buffer #(.DEPTH(4), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .router_id(router_id), .in_data(in_data),
      .in_valid(in_valid), .out_data(out_data_s), .out_valid(out_valid_s),
      .out_ready(out_ready), .full(full_s), .rx_done(rx_done_s),
      .drop_pulse(drop_pulse_s), .drop_count(drop_count_s), .miss_count(miss_count_s)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] dest, input logic [31:0] data);
      in_valid        = 1'b1;
      in_data.dest_id = dest;
      in_data.data    = data;
   endtask

   task automatic test_reset();
      rst = 1'b1; router_id = 16'd1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
      total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data); else passed++;
      total++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else passed++;
      total++; if ({rx_done, drop_pulse} !== 2'b00) $display("FAIL reset_pulses: got %b expected 00", {rx_done, drop_pulse}); else passed++;
      total++; if ({drop_count, miss_count} !== 32'd0) $display("FAIL reset_counters: got %h expected 0", {drop_count, miss_count}); else passed++;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(16'd1, 32'hDEADBEEF);
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else passed++;
      total++; if (out_data.data !== 32'hDEADBEEF) $display("FAIL basic_data: got %h expected deadbeef", out_data.data); else passed++;
      total++; if (rx_done !== 1'b1) $display("FAIL basic_rx_done: got %b expected 1", rx_done); else passed++;
      step();
      total++; if ({out_valid, rx_done} !== 2'b00) $display("FAIL basic_after_pop: got %b expected 00", {out_valid, rx_done}); else passed++;
      total++; if ({drop_count, miss_count} !== 32'd0) $display("FAIL basic_counters: got %h expected 0", {drop_count, miss_count}); else passed++;
   endtask

   task automatic test_filter();
      for (int i = 0; i < 3; i++) begin
         send(16'd0, 32'h100 + 32'(i));
         step();
         total++; if ({out_valid, rx_done} !== 2'b00) $display("FAIL filter_no_store: got %b expected 00", {out_valid, rx_done}); else passed++;
      end
      in_valid = 1'b0;
      total++; if (miss_count !== 16'd3) $display("FAIL filter_miss_count: got %0d expected 3", miss_count); else passed++;
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         send(16'd1, 32'(i));
         step();
         if (i == 4) begin
            total++; if (full !== 1'b1) $display("FAIL ovf_full_at_4: got %b expected 1", full); else passed++;
         end
         if (i == 5) begin
            total++; if ({drop_pulse, rx_done} !== 2'b10) $display("FAIL ovf_drop_pulse: got %b expected 10", {drop_pulse, rx_done}); else passed++;
         end
      end
      in_valid = 1'b0;
      total++; if (drop_count !== 16'd2) $display("FAIL ovf_drop_count: got %0d expected 2", drop_count); else passed++;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         total++; if (!(out_valid === 1'b1 && out_data.data === 32'(i))) $display("FAIL ovf_drain: got v=%b d=%h expected v=1 d=%h", out_valid, out_data.data, 32'(i)); else passed++;
         step();
      end
      total++; if (out_valid !== 1'b0) $display("FAIL ovf_empty: got %b expected 0", out_valid); else passed++;
   endtask

   task automatic test_full_pop();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(16'd1, 32'h10 + 32'(i));
         step();
      end
      out_ready = 1'b1;
      send(16'd1, 32'h14);
      step();
      in_valid = 1'b0;
      total++; if ({rx_done, drop_pulse} !== 2'b10) $display("FAIL fullpop_pulses: got %b expected 10", {rx_done, drop_pulse}); else passed++;
      total++; if (full !== 1'b1) $display("FAIL fullpop_count4: got full=%b expected 1", full); else passed++;
      total++; if (drop_count !== 16'd2) $display("FAIL fullpop_drop_count: got %0d expected 2", drop_count); else passed++;
      for (int i = 1; i <= 4; i++) begin
         total++; if (!(out_valid === 1'b1 && out_data.data === 32'h10 + 32'(i))) $display("FAIL fullpop_drain: got v=%b d=%h expected v=1 d=%h", out_valid, out_data.data, 32'h10 + 32'(i)); else passed++;
         step();
      end
      total++; if (out_valid !== 1'b0) $display("FAIL fullpop_empty: got %b expected 0", out_valid); else passed++;
   endtask

   task automatic test_saturation();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(16'd1, 32'h20 + 32'(i));
         step();
      end
      // Both instances already hold 2 drops from the overflow scenario.
      for (int i = 1; i <= 20; i++) begin
         send(16'd1, 32'h30 + 32'(i));
         step();
         if (i == 12) begin
            total++; if (drop_count_s !== 4'd14) $display("FAIL sat_before: got %0d expected 14", drop_count_s); else passed++;
         end
      end
      in_valid = 1'b0;
      total++; if (drop_count_s !== 4'd15) $display("FAIL sat_hold: got %0d expected 15", drop_count_s); else passed++;
      total++; if (drop_count !== 16'd22) $display("FAIL sat_wide: got %0d expected 22", drop_count); else passed++;
      total++; if (drop_pulse_s !== 1'b1) $display("FAIL sat_pulse: got %b expected 1", drop_pulse_s); else passed++;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      total++; if ({out_valid, full, out_data.data} !== {2'b10, 32'h21}) $display("FAIL mid_three_left: got v=%b f=%b d=%h expected v=1 f=0 d=21", out_valid, full, out_data.data); else passed++;
      rst = 1'b1;
      #1;
      total++; if ({out_valid, full} !== 2'b00) $display("FAIL mid_async_clear: got %b expected 00", {out_valid, full}); else passed++;
      total++; if ({drop_count, miss_count} !== 32'd0) $display("FAIL mid_counters: got %h expected 0", {drop_count, miss_count}); else passed++;
      send(16'd1, 32'h77);
      step();
      send(16'd0, 32'h78);
      step();
      in_valid = 1'b0;
      rst = 1'b0;
      step();
      total++; if ({out_valid, rx_done, drop_count, miss_count} !== 34'd0) $display("FAIL mid_ignored_in_reset: got %h expected 0", {out_valid, rx_done, drop_count, miss_count}); else passed++;
      send(16'd1, 32'hA5);
      step();
      in_valid = 1'b0;
      total++; if (!(out_valid === 1'b1 && out_data.data === 32'hA5)) $display("FAIL mid_next_pkt: got v=%b d=%h expected v=1 d=a5", out_valid, out_data.data); else passed++;
      out_ready = 1'b1;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL mid_alone: got %b expected 0", out_valid); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_filter();
      test_overflow();
      test_full_pop();
      test_saturation();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
